// File: rtl/pattern_cmd_loader.sv
// Byte-stream command parser in front of the serial output stage.
// Assembles output/frequency patterns from LSB-first payload bytes, issues
// start/stop pulses and tracks whether the serial stage is running.
//
// Handshake: the only input handshake is the receiver strobe. A byte on
// i_rx_data is consumed exactly on the rising edge where i_rx_done_tick=1;
// there is no back-pressure, so bytes arriving in S_COMMIT are dropped.
// All outputs are registered. Pulse outputs are high for exactly one cycle.
module pattern_cmd_loader #(
  parameter int DATA_BIT       = 32,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_done_tick,
  input  logic                i_done_tick,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_mode,
  output logic                o_busy,
  output logic                o_load_tick,
  output logic                o_cmd_error,
  output logic [1:0]          o_dbg_state
);

  localparam int BYTES = DATA_BIT / 8;
  localparam int BC_W  = $clog2(BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] S_CMD     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  localparam logic [7:0] OP_LOAD_OUT  = 8'h01;
  localparam logic [7:0] OP_LOAD_FREQ = 8'h02;
  localparam logic [7:0] OP_START_ONE = 8'h03;
  localparam logic [7:0] OP_START_REP = 8'h04;
  localparam logic [7:0] OP_STOP      = 8'h05;

  logic [1:0]          state_q, state_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [DATA_BIT-1:0] shadow_q, shadow_d;
  logic                target_q, target_d;   // 0 = output pattern, 1 = freq pattern
  logic [DATA_BIT-1:0] out_pat_q, out_pat_d;
  logic [DATA_BIT-1:0] freq_pat_q, freq_pat_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                mode_q, mode_d;
  logic                busy_q, busy_d;
  logic                load_q, load_d;
  logic                err_q, err_d;
  logic                busy_eff;

  // A one-shot done tick clears busy before the current byte is decoded,
  // so a start byte in the same cycle is accepted.
  assign busy_eff = busy_q & ~(i_done_tick & ~mode_q);

  // Next-state logic for the parser FSM, counters, patterns and pulses.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    to_cnt_d   = '0;
    shadow_d   = shadow_q;
    target_d   = target_q;
    out_pat_d  = out_pat_q;
    freq_pat_d = freq_pat_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    mode_d     = mode_q;
    busy_d     = busy_eff;
    load_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_CMD: begin
        if (i_rx_done_tick) begin
          case (i_rx_data)
            OP_LOAD_OUT, OP_LOAD_FREQ: begin
              target_d   = (i_rx_data == OP_LOAD_FREQ);
              shadow_d   = '0;
              byte_cnt_d = '0;
              state_d    = S_PAYLOAD;
            end
            OP_START_ONE, OP_START_REP: begin
              if (!busy_eff) begin
                mode_d  = (i_rx_data == OP_START_REP);
                start_d = 1'b1;
                busy_d  = 1'b1;
              end
            end
            OP_STOP: begin
              stop_d = 1'b1;
              busy_d = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      S_PAYLOAD: begin
        if (i_rx_done_tick) begin
          shadow_d[int'(byte_cnt_q)*8 +: 8] = i_rx_data;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BC_W'(BYTES - 1)) state_d = S_COMMIT;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Too long since the last byte: abandon the partial payload.
          shadow_d   = '0;
          byte_cnt_d = '0;
          err_d      = 1'b1;
          state_d    = S_CMD;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end

      S_COMMIT: begin
        if (target_q) freq_pat_d = shadow_q;
        else          out_pat_d  = shadow_q;
        load_d     = 1'b1;
        byte_cnt_d = '0;
        state_d    = S_CMD;
      end

      default: state_d = S_CMD;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CMD;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      shadow_q   <= '0;
      target_q   <= 1'b0;
      out_pat_q  <= '0;
      freq_pat_q <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      to_cnt_q   <= to_cnt_d;
      shadow_q   <= shadow_d;
      target_q   <= target_d;
      out_pat_q  <= out_pat_d;
      freq_pat_q <= freq_pat_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      err_q      <= err_d;
    end
  end

  assign o_output_pattern = out_pat_q;
  assign o_freq_pattern   = freq_pat_q;
  assign o_start          = start_q;
  assign o_stop           = stop_q;
  assign o_mode           = mode_q;
  assign o_busy           = busy_q;
  assign o_load_tick      = load_q;
  assign o_cmd_error      = err_q;
  assign o_dbg_state      = state_q;

endmodule
